// File: rtl/dma_pkg.sv
// Shared types for the multi-channel fly-by DMA controller: FSM states,
// transfer direction, per-channel configuration record and strobe decoding.
package dma_pkg;

    // Record field widths; controller ADDR_W/CNT_W must not exceed these.
    localparam int DMA_ADDR_W = 10;
    localparam int DMA_CNT_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } dma_state_e;

    typedef enum logic {
        DIR_MEM2IO = 1'b0,  // MEMR + IOW
        DIR_IO2MEM = 1'b1   // IOR + MEMW
    } dma_dir_e;

    typedef struct packed {
        dma_dir_e              dir;
        logic [DMA_ADDR_W-1:0] dram_addr;
        logic [DMA_ADDR_W-1:0] io_addr;
        logic [DMA_CNT_W-1:0]  count;
    } dma_cfg_t;

    typedef struct packed {
        logic ior;
        logic iow;
        logic memr;
        logic memw;
    } dma_strobe_t;

    function automatic dma_strobe_t dir_strobes(input dma_dir_e dir);
        dma_strobe_t s;
        s      = '0;
        s.ior  = (dir == DIR_IO2MEM);
        s.memw = (dir == DIR_IO2MEM);
        s.memr = (dir == DIR_MEM2IO);
        s.iow  = (dir == DIR_MEM2IO);
        return s;
    endfunction

endpackage

// File: rtl/dma_mc_controller_if.sv
// Bus/handshake bundle of the DMA controller; slave = controller side,
// master = CPU / configuration side.
interface dma_mc_controller_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              CFG_WE;
    logic [CH_W-1:0]   CFG_CH;
    logic              CFG_DIR;
    logic [ADDR_W-1:0] CFG_DRAM_ADDR;
    logic [ADDR_W-1:0] CFG_IO_ADDR;
    logic [CNT_W-1:0]  CFG_COUNT;

    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic              IOR_command;
    logic              IOW_command;
    logic              MEMR;
    logic              MEMW;
    logic [ADDR_W-1:0] addressBus_DRAM;
    logic [ADDR_W-1:0] addressBus_IO;
    logic              EOP;
    logic [NUM_CH-1:0] TC;
    logic              BUSY;

    modport slave (
        input  DREQ, HLDA, CFG_WE, CFG_CH, CFG_DIR, CFG_DRAM_ADDR, CFG_IO_ADDR, CFG_COUNT,
        output HRQ, DACK, IOR_command, IOW_command, MEMR, MEMW,
               addressBus_DRAM, addressBus_IO, EOP, TC, BUSY
    );

    modport master (
        output DREQ, HLDA, CFG_WE, CFG_CH, CFG_DIR, CFG_DRAM_ADDR, CFG_IO_ADDR, CFG_COUNT,
        input  HRQ, DACK, IOR_command, IOW_command, MEMR, MEMW,
               addressBus_DRAM, addressBus_IO, EOP, TC, BUSY
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester found after the
// last granted channel, wrapping so the last channel itself is tried last.
module dma_rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [NUM_CH-1:0] gnt_o
);

    int idx;

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_o = '0;
        idx   = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NUM_CH;
            if (req_i[idx]) gnt_o = NUM_CH'(1) << idx;
        end
    end

endmodule

// File: rtl/dma_mc_controller.sv
// Multi-channel demand-mode fly-by DMA controller (IDLE/REQ/XFER/DONE).
// Optional feature macro DMA_AUTOINIT_EN: DONE reloads the programmed base values.
module dma_mc_controller
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic               CLK,
    input  logic               RST_N,
    dma_mc_controller_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    dma_state_e        state_q;
    logic [CH_W-1:0]   ch_q;       // latched channel, doubles as last-grant pointer
    dma_cfg_t          cfg_q [NUM_CH];
`ifdef DMA_AUTOINIT_EN
    dma_cfg_t          base_q [NUM_CH];
`endif
    logic              hrq_q;
    logic              eop_q;
    logic [NUM_CH-1:0] dack_q;
    logic [NUM_CH-1:0] tc_q;
    dma_strobe_t       strb_q;
    logic [ADDR_W-1:0] dram_q;
    logic [ADDR_W-1:0] io_q;

    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;
    dma_cfg_t          cur;
    dma_cfg_t          cfg_wr;
    logic              cfg_ok;
    logic [ADDR_W-1:0] dram_d;
    logic [ADDR_W-1:0] io_d;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_CH; i++)
            req_vec[i] = bus.DREQ[i] && (cfg_q[i].count != '0);
    end

    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i  (req_vec),
        .last_i (ch_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (gnt[i]) gnt_idx = CH_W'(i);
    end
    assign gnt_vld = |gnt;

    assign cur    = cfg_q[ch_q];
    assign dram_d = ADDR_W'(cur.dram_addr) + ADDR_W'(1);
    assign io_d   = ADDR_W'(cur.io_addr) + ADDR_W'(1);
    assign cnt_d  = CNT_W'(cur.count) - CNT_W'(1);

    // The latched channel is locked against reprogramming until back in IDLE.
    assign cfg_ok = bus.CFG_WE && (int'(bus.CFG_CH) < NUM_CH) &&
                    ((state_q == IDLE) || (bus.CFG_CH != ch_q));

    always_comb begin
        cfg_wr           = '0;
        cfg_wr.dir       = dma_dir_e'(bus.CFG_DIR);
        cfg_wr.dram_addr = DMA_ADDR_W'(bus.CFG_DRAM_ADDR);
        cfg_wr.io_addr   = DMA_ADDR_W'(bus.CFG_IO_ADDR);
        cfg_wr.count     = DMA_CNT_W'(bus.CFG_COUNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ch_q    <= CH_W'(NUM_CH - 1);
            hrq_q   <= 1'b0;
            eop_q   <= 1'b0;
            dack_q  <= '0;
            tc_q    <= '0;
            strb_q  <= '0;
            dram_q  <= '0;
            io_q    <= '0;
            // NOTE: the channel file is small and its counts must come up 0, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i]  <= '0;
`ifdef DMA_AUTOINIT_EN
                base_q[i] <= '0;
`endif
            end
        end else begin
            eop_q <= 1'b0;
            tc_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        ch_q    <= gnt_idx;
                        hrq_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.DREQ[ch_q]) begin
                        hrq_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.HLDA) begin
                        dack_q  <= NUM_CH'(1) << ch_q;
                        strb_q  <= dir_strobes(cur.dir);
                        dram_q  <= ADDR_W'(cur.dram_addr);
                        io_q    <= ADDR_W'(cur.io_addr);
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    cfg_q[ch_q].dram_addr <= DMA_ADDR_W'(dram_d);
                    cfg_q[ch_q].io_addr   <= DMA_ADDR_W'(io_d);
                    cfg_q[ch_q].count     <= DMA_CNT_W'(cnt_d);
                    if (cnt_d == '0) begin
                        hrq_q   <= 1'b0;
                        dack_q  <= '0;
                        strb_q  <= '0;
                        dram_q  <= '0;
                        io_q    <= '0;
                        eop_q   <= 1'b1;
                        tc_q    <= NUM_CH'(1) << ch_q;
                        state_q <= DONE;
                    end else if (bus.DREQ[ch_q] && bus.HLDA) begin
                        dram_q <= dram_d;
                        io_q   <= io_d;
                    end else begin
                        // Demand-mode pause: progress stays in cfg_q for the next grant.
                        hrq_q   <= 1'b0;
                        dack_q  <= '0;
                        strb_q  <= '0;
                        dram_q  <= '0;
                        io_q    <= '0;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
`ifdef DMA_AUTOINIT_EN
                    cfg_q[ch_q] <= base_q[ch_q];
`else
                    cfg_q[ch_q].count <= '0;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (cfg_ok) begin
                cfg_q[bus.CFG_CH]  <= cfg_wr;
`ifdef DMA_AUTOINIT_EN
                base_q[bus.CFG_CH] <= cfg_wr;
`endif
            end
        end
    end

    assign bus.HRQ             = hrq_q;
    assign bus.DACK            = dack_q;
    assign bus.IOR_command     = strb_q.ior;
    assign bus.IOW_command     = strb_q.iow;
    assign bus.MEMR            = strb_q.memr;
    assign bus.MEMW            = strb_q.memw;
    assign bus.addressBus_DRAM = dram_q;
    assign bus.addressBus_IO   = io_q;
    assign bus.EOP             = eop_q;
    assign bus.TC              = tc_q;
    assign bus.BUSY            = (state_q != IDLE);

endmodule

// File: tb/tb_dma_mc_controller.sv
// Directed self-checking bench for dma_mc_controller (4 channels, 10-bit buses).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_dma_mc_controller;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_errors;

    dma_mc_controller_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    dma_mc_controller #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ctl = {HRQ, DACK, IOR, IOW, MEMR, MEMW, EOP, TC, BUSY}
    task automatic expect_bus(input string tag, input logic hrq, input logic [3:0] dack,
                              input logic [3:0] str, input logic eop, input logic [3:0] tc,
                              input logic busy, input logic [9:0] dram, input logic [9:0] io);
        check({tag, ".ctl"},
              32'({bus.HRQ, bus.DACK, bus.IOR_command, bus.IOW_command, bus.MEMR, bus.MEMW,
                   bus.EOP, bus.TC, bus.BUSY}),
              32'({hrq, dack, str, eop, tc, busy}));
        check({tag, ".addr"}, 32'({bus.addressBus_DRAM, bus.addressBus_IO}), 32'({dram, io}));
        check({tag, ".excl"},
              32'((bus.IOR_command & bus.IOW_command) | (bus.MEMR & bus.MEMW)), 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        expect_bus(tag, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 10'h0, 10'h0);
    endtask

    task automatic expect_req(input string tag);
        expect_bus(tag, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 10'h0, 10'h0);
    endtask

    task automatic cfg_write(input int ch, input logic dir, input logic [9:0] dram,
                             input logic [9:0] io, input logic [9:0] cnt);
        bus.CFG_CH        = 2'(ch);
        bus.CFG_DIR       = dir;
        bus.CFG_DRAM_ADDR = dram;
        bus.CFG_IO_ADDR   = io;
        bus.CFG_COUNT     = cnt;
        bus.CFG_WE        = 1'b1;
        step();
        bus.CFG_WE        = 1'b0;
    endtask

    // From IDLE with DREQ asserted: REQ, optional HLDA delay, n words, DONE, IDLE.
    task automatic run_burst(input string tag, input int ch, input logic dir,
                             input logic [9:0] dram0, input logic [9:0] io0,
                             input int n, input int hold);
        logic [3:0] oh;
        logic [3:0] str;
        oh  = 4'b0001 << ch;
        str = dir ? 4'b1001 : 4'b0110;
        step();
        expect_req({tag, ".req"});
        for (int h = 0; h < hold; h++) begin
            step();
            expect_req($sformatf("%s.hold%0d", tag, h));
        end
        bus.HLDA = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            expect_bus($sformatf("%s.w%0d", tag, i), 1'b1, oh, str, 1'b0, 4'h0, 1'b1,
                       10'(dram0 + 10'(i)), 10'(io0 + 10'(i)));
        end
        step();
        expect_bus({tag, ".done"}, 1'b0, 4'h0, 4'h0, 1'b1, oh, 1'b1, 10'h0, 10'h0);
        step();
        expect_idle({tag, ".idle"});
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        bus.DREQ          = '0;
        bus.HLDA          = 1'b0;
        bus.CFG_WE        = 1'b0;
        bus.CFG_CH        = '0;
        bus.CFG_DIR       = 1'b0;
        bus.CFG_DRAM_ADDR = '0;
        bus.CFG_IO_ADDR   = '0;
        bus.CFG_COUNT     = '0;
        RST_N             = 1'b1;
        #1 RST_N = 1'b0;
        #1 expect_idle("reset");
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        step();
        expect_idle("post_reset");

        // Single channel I/O->DRAM, HLDA arrives two cycles after HRQ.
        cfg_write(0, 1'b1, 10'h100, 10'h020, 10'd3);
        bus.DREQ = 4'b0001;
        run_burst("t1", 0, 1'b1, 10'h100, 10'h020, 3, 2);
        bus.DREQ = 4'b0000;

        // Two contenders; pointer sits at 0, so channel 1 goes first.
        cfg_write(1, 1'b0, 10'h010, 10'h001, 10'd1);
        cfg_write(2, 1'b0, 10'h020, 10'h002, 10'd1);
        bus.DREQ = 4'b0110;
        run_burst("t2a", 1, 1'b0, 10'h010, 10'h001, 1, 0);
        run_burst("t2b", 2, 1'b0, 10'h020, 10'h002, 1, 0);
        bus.DREQ = 4'b0000;

        // Address wrap on both buses.
        cfg_write(3, 1'b1, 10'h3FE, 10'h3FF, 10'd4);
        bus.DREQ = 4'b1000;
        run_burst("t3", 3, 1'b1, 10'h3FE, 10'h3FF, 4, 0);
`ifndef DMA_AUTOINIT_EN
        step();
        step();
        expect_idle("t3.disabled");
`endif
        bus.DREQ = 4'b0000;

        // Demand-mode pause after two of five words, then resume.
        cfg_write(0, 1'b0, 10'h200, 10'h040, 10'd5);
        bus.DREQ = 4'b0001;
        step();
        expect_req("t4.req");
        step();
        expect_bus("t4.w0", 1'b1, 4'b0001, 4'b0110, 1'b0, 4'h0, 1'b1, 10'h200, 10'h040);
        step();
        expect_bus("t4.w1", 1'b1, 4'b0001, 4'b0110, 1'b0, 4'h0, 1'b1, 10'h201, 10'h041);
        bus.DREQ = 4'b0000;
        step();
        expect_idle("t4.pause");
        step();
        expect_idle("t4.paused");
        bus.DREQ = 4'b0001;
        run_burst("t4r", 0, 1'b0, 10'h202, 10'h042, 3, 0);
        bus.DREQ = 4'b0000;

        // Reprogramming the active channel is ignored; reset aborts mid-transfer.
        cfg_write(1, 1'b1, 10'h050, 10'h005, 10'd6);
        bus.DREQ = 4'b0010;
        step();
        expect_req("t5.req");
        step();
        expect_bus("t5.w0", 1'b1, 4'b0010, 4'b1001, 1'b0, 4'h0, 1'b1, 10'h050, 10'h005);
        bus.CFG_CH        = 2'd1;
        bus.CFG_DIR       = 1'b0;
        bus.CFG_DRAM_ADDR = 10'h123;
        bus.CFG_IO_ADDR   = 10'h111;
        bus.CFG_COUNT     = 10'd1;
        bus.CFG_WE        = 1'b1;
        step();
        bus.CFG_WE        = 1'b0;
        expect_bus("t5.w1", 1'b1, 4'b0010, 4'b1001, 1'b0, 4'h0, 1'b1, 10'h051, 10'h006);
        step();
        expect_bus("t5.w2", 1'b1, 4'b0010, 4'b1001, 1'b0, 4'h0, 1'b1, 10'h052, 10'h007);
        #2 RST_N = 1'b0;
        #1 expect_idle("t5.async_rst");
        step();
        expect_idle("t5.rst_held");
        RST_N = 1'b1;
        step();
        step();
        expect_idle("t5.counts_cleared");
        bus.DREQ = 4'b0000;

        // After reset the pointer is NUM_CH-1, so channel 0 wins over channel 1.
        cfg_write(0, 1'b1, 10'h001, 10'h002, 10'd1);
        cfg_write(1, 1'b1, 10'h003, 10'h004, 10'd1);
        bus.DREQ = 4'b0011;
        run_burst("t6a", 0, 1'b1, 10'h001, 10'h002, 1, 0);
        run_burst("t6b", 1, 1'b1, 10'h003, 10'h004, 1, 0);
        bus.DREQ = 4'b0000;

`ifdef DMA_AUTOINIT_EN
        // Held request: every burst restarts from the programmed base.
        cfg_write(2, 1'b1, 10'h0A0, 10'h00A, 10'd2);
        bus.DREQ = 4'b0100;
        for (int b = 0; b < 3; b++)
            run_burst($sformatf("ai%0d", b), 2, 1'b1, 10'h0A0, 10'h00A, 2, 0);
        bus.DREQ = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
